// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared constants, types and helpers for the SHA-256 message padder.
//   BLOCK_W    : compression block width in bits
//   BYTE_W     : byte width
//   NUM_BYTES  : bytes per block
//   LEN_OFFSET : first byte of the 64-bit length field
//   PAD_BYTE   : the single '1' bit appended after the message
//   pad_state_e: padder FSM states
//   byte_idx_t : byte position inside a block
// -----------------------------------------------------------------------------
package sha256_pkg;

    localparam int unsigned BLOCK_W    = 512;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned NUM_BYTES  = BLOCK_W / BYTE_W;
    localparam logic [5:0]  LEN_OFFSET = 6'd56;
    localparam logic [7:0]  PAD_BYTE   = 8'h80;

    typedef logic [5:0] byte_idx_t;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        LEN,
        EMIT
    } pad_state_e;

    // Byte k (0 = most significant) of the big-endian 64-bit length field.
    function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [2:0] k);
        return len[8 * (7 - int'(k)) +: 8];
    endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// -----------------------------------------------------------------------------
// sha256_blk_buf
// 512-bit block assembly register, byte 0 held in bits [511:504].
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset (clears the buffer)
//   i_clr       : synchronous clear, wins over both write ports
//   i_we        : single-byte write enable
//   i_widx      : byte index for the single-byte write
//   i_wdata     : byte to write
//   i_mask_we   : masked multi-byte write enable
//   i_mask      : per-byte enables for the masked write (bit b -> byte b)
//   i_mask_data : block-aligned data for the masked write
//   o_data      : current buffer contents
// -----------------------------------------------------------------------------
module sha256_blk_buf
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_we,
    input  logic [5:0]   i_widx,
    input  logic [7:0]   i_wdata,
    input  logic         i_mask_we,
    input  logic [63:0]  i_mask,
    input  logic [511:0] i_mask_data,
    output logic [511:0] o_data
);

    logic [511:0] r_buf;
    logic [511:0] w_buf_d;

    always_comb begin
        w_buf_d = r_buf;
        if (i_clr) begin
            w_buf_d = '0;
        end else begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (i_we && (i_widx == 6'(b))) begin
                    w_buf_d[BLOCK_W - BYTE_W * (b + 1) +: BYTE_W] = i_wdata;
                end
                if (i_mask_we && i_mask[b]) begin
                    w_buf_d[BLOCK_W - BYTE_W * (b + 1) +: BYTE_W] =
                        i_mask_data[BLOCK_W - BYTE_W * (b + 1) +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf <= '0;
        end else begin
            r_buf <= w_buf_d;
        end
    end

    assign o_data = r_buf;

endmodule

// File: rtl/sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder
// Byte-stream to 512-bit block producer for a SHA-256 core. Appends 0x80,
// zero fill and the 64-bit big-endian message bit length to every message.
// Ports:
//   clk, rst               : clock (rising edge), async active-high reset
//   in_valid/in_ready      : input beat handshake
//   in_data                : message byte
//   in_last                : beat ends the message
//   in_empty               : beat carries no byte (with in_last only)
//   blk_valid/blk_ready    : block handshake towards the core
//   blk_data               : block, byte 0 in [511:504]
//   blk_first / blk_last   : first / final padded block of a message
// Build option:
//   SHA256_PAD_FASTFILL_EN : padding and length written in one clock each
//                            through the masked write port of the buffer.
// -----------------------------------------------------------------------------
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    pad_state_e       r_state, w_state_d;
    byte_idx_t        r_idx, w_idx_d;
    logic [LEN_W-1:0] r_bit_len, w_bit_len_d;
    logic             r_first_pend, w_first_pend_d;
    logic             r_pad_first, w_pad_first_d;   // next PAD write is the 0x80
    logic             r_resume_pad, w_resume_pad_d; // after a non-final EMIT go to PAD
    logic             r_last, w_last_d;              // EMIT holds the final block

    logic         w_beat;
    logic         w_clr;
    logic         w_we;
    logic [7:0]   w_wdata;
    logic         w_mask_we;
    logic [63:0]  w_mask;
    logic [511:0] w_mask_data;
    logic [511:0] w_buf;
    logic [63:0]  w_len64;

    assign w_len64  = 64'(r_bit_len);
    assign in_ready = (r_state == FILL) && !rst;
    assign w_beat   = in_valid && in_ready;

    always_comb begin
        w_state_d      = r_state;
        w_idx_d        = r_idx;
        w_bit_len_d    = r_bit_len;
        w_first_pend_d = r_first_pend;
        w_pad_first_d  = r_pad_first;
        w_resume_pad_d = r_resume_pad;
        w_last_d       = r_last;
        w_clr          = 1'b0;
        w_we           = 1'b0;
        w_wdata        = 8'h00;
        w_mask_we      = 1'b0;

        unique case (r_state)
            FILL: begin
                if (w_beat) begin
                    if (in_empty) begin
                        if (in_last) begin
                            w_state_d     = PAD;
                            w_pad_first_d = 1'b1;
                        end
                    end else begin
                        w_we        = 1'b1;
                        w_wdata     = in_data;
                        w_idx_d     = r_idx + 6'd1;
                        w_bit_len_d = r_bit_len + LEN_W'(8);
                        if (r_idx == 6'd63) begin
                            // Block full: ship it, then pad from byte 0 if the message ended.
                            w_state_d      = EMIT;
                            w_last_d       = 1'b0;
                            w_resume_pad_d = in_last;
                            w_pad_first_d  = 1'b1;
                        end else if (in_last) begin
                            w_state_d     = PAD;
                            w_pad_first_d = 1'b1;
                        end
                    end
                end
            end

            PAD: begin
                w_pad_first_d = 1'b0;
`ifdef SHA256_PAD_FASTFILL_EN
                w_mask_we = 1'b1;
                if (r_idx >= LEN_OFFSET) begin
                    w_idx_d        = 6'd0;
                    w_state_d      = EMIT;
                    w_last_d       = 1'b0;
                    w_resume_pad_d = 1'b1;
                end else begin
                    w_idx_d   = LEN_OFFSET;
                    w_state_d = LEN;
                end
`else
                w_we    = 1'b1;
                w_wdata = r_pad_first ? PAD_BYTE : 8'h00;
                w_idx_d = r_idx + 6'd1;
                if (r_idx == LEN_OFFSET - 6'd1) begin
                    w_state_d = LEN;
                end else if (r_idx == 6'd63) begin
                    // No room for the length field: finish this block with zeros.
                    w_state_d      = EMIT;
                    w_last_d       = 1'b0;
                    w_resume_pad_d = 1'b1;
                end
`endif
            end

            LEN: begin
`ifdef SHA256_PAD_FASTFILL_EN
                w_mask_we = 1'b1;
                w_idx_d   = 6'd0;
                w_state_d = EMIT;
                w_last_d  = 1'b1;
`else
                w_we    = 1'b1;
                w_wdata = len_byte(w_len64, r_idx[2:0]);
                w_idx_d = r_idx + 6'd1;
                if (r_idx == 6'd63) begin
                    w_state_d = EMIT;
                    w_last_d  = 1'b1;
                end
`endif
            end

            EMIT: begin
                if (blk_ready) begin
                    w_clr          = 1'b1;
                    w_idx_d        = 6'd0;
                    w_first_pend_d = 1'b0;
                    if (r_last) begin
                        w_first_pend_d = 1'b1;
                        w_bit_len_d    = '0;
                        w_state_d      = FILL;
                    end else begin
                        w_state_d = r_resume_pad ? PAD : FILL;
                    end
                end
            end

            default: w_state_d = FILL;
        endcase
    end

`ifdef SHA256_PAD_FASTFILL_EN
    logic w_wrap;
    assign w_wrap = (r_idx >= LEN_OFFSET);

    // Byte enables: LEN covers bytes 56..63; PAD covers idx..55, or idx..63 when
    // the length field no longer fits in this block.
    always_comb begin
        w_mask      = '0;
        w_mask_data = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (r_state == LEN) begin
                if (6'(b) >= LEN_OFFSET) begin
                    w_mask[b] = 1'b1;
                    w_mask_data[BLOCK_W - BYTE_W * (b + 1) +: BYTE_W] =
                        len_byte(w_len64, 3'(b));
                end
            end else if ((6'(b) >= r_idx) && (w_wrap || (6'(b) < LEN_OFFSET))) begin
                w_mask[b] = 1'b1;
                if ((6'(b) == r_idx) && r_pad_first) begin
                    w_mask_data[BLOCK_W - BYTE_W * (b + 1) +: BYTE_W] = PAD_BYTE;
                end
            end
        end
    end
`else
    assign w_mask      = '0;
    assign w_mask_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_bit_len    <= '0;
            r_first_pend <= 1'b1;
            r_pad_first  <= 1'b0;
            r_resume_pad <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_bit_len    <= w_bit_len_d;
            r_first_pend <= w_first_pend_d;
            r_pad_first  <= w_pad_first_d;
            r_resume_pad <= w_resume_pad_d;
            r_last       <= w_last_d;
        end
    end

    sha256_blk_buf u_blk_buf (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_we        (w_we),
        .i_widx      (r_idx),
        .i_wdata     (w_wdata),
        .i_mask_we   (w_mask_we),
        .i_mask      (w_mask),
        .i_mask_data (w_mask_data),
        .o_data      (w_buf)
    );

    assign blk_valid = (r_state == EMIT);
    assign blk_first = blk_valid && r_first_pend;
    assign blk_last  = blk_valid && r_last;
    assign blk_data  = blk_valid ? w_buf : '0;

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_empty;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ready_mode = 2;  // 0 random, 1 held low, 2 held high
    exp_t exp_q[$];

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference model: padded byte string built from the padding rules, then cut
    // into 64-byte blocks.
    function automatic void model_push(input bq_t msg);
        bq_t          pad;
        logic [63:0]  bits;
        int           nblk;
        exp_t         e;
        pad  = msg;
        bits = 64'(msg.size()) * 64'd8;
        pad.push_back(8'h80);
        while ((pad.size() % 64) != 56) pad.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pad.push_back(8'(bits >> (8 * i)));
        nblk = pad.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int i = 0; i < 64; i++) e.data[511 - 8 * i -: 8] = pad[b * 64 + i];
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void push_const(input logic [511:0] d);
        exp_t e;
        e.data  = d;
        e.first = 1'b1;
        e.last  = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Monitor: a block transfers at the next rising edge when valid&&ready here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_block: got %h required none", blk_data);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data", blk_data, e.data);
                    check("blk_first", 512'(blk_first), 512'(e.first));
                    check("blk_last", 512'(blk_last), 512'(e.last));
                end
            end
        end
    end

    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       blk_ready = ($urandom_range(0, 3) != 0);
                1:       blk_ready = 1'b0;
                default: blk_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        bit ok;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept: got timeout required accepted");
        end
    endtask

    task automatic send_msg(input bq_t msg, input bit late_end, input bit push);
        if (push) model_push(msg);
        if (msg.size() == 0) begin
            send_beat(8'h00, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < msg.size(); i++)
                send_beat(msg[i], (i == msg.size() - 1) && !late_end, 1'b0);
            if (late_end) send_beat(8'h00, 1'b1, 1'b1);
        end
    endtask

    // Cycles from the edge accepting the last beat until blk_valid is seen.
    task automatic check_latency(input string name, input int exp_lat);
        int k = 0;
        while (!blk_valid && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 512'(k), 512'(exp_lat));
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic bq_t fill_msg(input int n, input logic [7:0] v);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(v);
        return q;
    endfunction

    initial begin
        bq_t          m;
        logic [511:0] c;
        logic [511:0] hold;
        int           k;
        int           len;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        in_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_blk_valid", 512'(blk_valid), 512'(0));
        check("rst_blk_data", blk_data, 512'(0));
        check("rst_first_last", 512'({blk_first, blk_last}), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 512'(in_ready), 512'(1));

        // "abc"
        ready_mode = 2;
        c = '0;
        c[511:480] = 32'h61626380;
        c[63:0] = 64'h18;
        push_const(c);
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0, 1'b0);
`ifdef SHA256_PAD_FASTFILL_EN
        check_latency("abc_latency", 2);
`else
        check_latency("abc_latency", 61);
`endif
        drain();

        // empty message
        c = '0;
        c[511:480] = 32'h80000000;
        push_const(c);
        m = {};
        send_msg(m, 1'b0, 1'b0);
`ifdef SHA256_PAD_FASTFILL_EN
        check_latency("empty_latency", 2);
`else
        check_latency("empty_latency", 64);
`endif
        drain();

        // length boundaries around the length field
        ready_mode = 0;
        send_msg(fill_msg(55, 8'h41), 1'b0, 1'b1);
        send_msg(fill_msg(56, 8'h41), 1'b0, 1'b1);
        send_msg(fill_msg(64, 8'h41), 1'b0, 1'b1);
        send_msg(fill_msg(64, 8'h42), 1'b1, 1'b1);
        drain();

        // backpressure on block 1 of a 100-byte message
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        fork
            send_msg(fill_msg(100, 8'h41), 1'b0, 1'b1);
            begin
                k = 0;
                while (!blk_valid && k < 500) begin
                    @(negedge clk);
                    k++;
                end
                check("stall_valid_seen", 512'(blk_valid), 512'(1));
                hold = blk_data;
                for (int cyc = 0; cyc < 10; cyc++) begin
                    @(negedge clk);
                    check("stall_blk_valid", 512'(blk_valid), 512'(1));
                    check("stall_blk_data", blk_data, hold);
                    check("stall_in_ready", 512'(in_ready), 512'(0));
                end
                ready_mode = 2;
            end
        join
        drain();

        // random messages under random backpressure
        ready_mode = 0;
        for (int n = 0; n < 12; n++) begin
            len = $urandom_range(0, 140);
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            send_msg(m, (len > 0) && ($urandom_range(0, 1) == 1), 1'b1);
        end
        drain();

        // reset in the middle of padding message A, then "abc"
        ready_mode = 2;
        send_msg(fill_msg(20, 8'h5a), 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midpad_rst_in_ready", 512'(in_ready), 512'(0));
        check("midpad_rst_blk_valid", 512'(blk_valid), 512'(0));
        check("midpad_rst_blk_data", blk_data, 512'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        c = '0;
        c[511:480] = 32'h61626380;
        c[63:0] = 64'h18;
        push_const(c);
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
